// File: rtl/product_accumulator.sv
// product_accumulator
// Sums each group of COUNT consecutive accepted products into one result and
// presents it on a valid/ready output backed by a single pending buffer.
// Beats that arrive while the pending buffer is occupied are dropped, and the
// sticky overrun flag records the drop.
// Optional: define PRODUCT_ACC_SATURATE_EN to make every addition clamp at
// all-ones instead of wrapping modulo 2^ACC_WIDTH.
module product_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned COUNT     = 4,
    parameter int unsigned ACC_WIDTH = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [2*WIDTH-1:0]     in_product,
    output logic                   in_ready,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic                   overrun
);

    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] pend_sum;
    logic                 pend;

    logic                 accept;
    logic                 final_beat;
    logic                 slot_free;
    logic                 xfer;
    logic [ACC_WIDTH-1:0] sum_next;

    // Accumulator plus zero-extended product, wrapping or clamping.
    function automatic logic [ACC_WIDTH-1:0] acc_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [2*WIDTH-1:0]   b
    );
`ifdef PRODUCT_ACC_SATURATE_EN
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH+1)'(b);
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'(b);
`endif
    endfunction

    // Accept / handshake qualifiers derived from current register state.
    always_comb begin
        in_ready   = !pend;
        accept     = in_valid && !pend && !clear;
        final_beat = accept && (cnt == CNT_W'(COUNT - 1));
        slot_free  = !out_valid || out_ready;
        xfer       = out_valid && out_ready;
        sum_next   = acc_add(acc, in_product);
    end

    // Group accumulator and beat counter; clear wins over accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (final_beat) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output slot and pending buffer. A final beat can only be accepted with
    // pend=0, so a new result and a pend drain never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
            pend_sum  <= '0;
            pend      <= 1'b0;
        end else if (final_beat) begin
            if (slot_free) begin
                out_sum   <= sum_next;
                out_valid <= 1'b1;
            end else begin
                pend_sum  <= sum_next;
                pend      <= 1'b1;
            end
        end else if (xfer) begin
            if (pend) begin
                out_sum <= pend_sum;
                pend    <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky drop flag: a beat offered while stalled (and not cleared).
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (in_valid && pend && !clear) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed scenarios followed by random traffic, checked every cycle against
// a queue-based reference of completed results.
module tb_product_accumulator;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned COUNT = 4;
    localparam int unsigned ACC   = 18;
    localparam int unsigned ACC2  = 17;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [15:0]       in_product = '0;
    logic              clear = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid, overrun;
    logic [ACC-1:0]    out_sum;
    logic              in_ready2, out_valid2, overrun2;
    logic [ACC2-1:0]   out_sum2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    longint unsigned res_q[$];
    longint unsigned g_sum = 0;
    int unsigned     g_cnt = 0;
    longint unsigned m_sum = 0;
    bit              m_ovr = 1'b0;

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product),
        .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .overrun(overrun)
    );

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC2)) dut17 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product),
        .in_ready(in_ready2), .clear(clear), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned fold(input longint unsigned s, input int unsigned w);
        longint unsigned lim;
        lim = (64'd1 << w);
`ifdef PRODUCT_ACC_SATURATE_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(res_q.size() > 0));
        check({tag, ".out_sum"},   64'(out_sum),   m_sum);
        check({tag, ".in_ready"},  64'(in_ready),  64'(res_q.size() < 2));
        check({tag, ".overrun"},   64'(overrun),   64'(m_ovr));
    endtask

    // One clock cycle of stimulus, model update and output check.
    task automatic step(input string tag, input logic v, input logic [15:0] p,
                        input logic c, input logic r);
        bit m_rdy;
        in_valid = v; in_product = p; clear = c; out_ready = r;
        @(posedge clk);
        m_rdy = (res_q.size() < 2);
        if (v && !m_rdy && !c) m_ovr = 1'b1;
        if (c) begin
            g_sum = 0; g_cnt = 0;
        end else if (v && m_rdy) begin
            g_sum += 64'(p); g_cnt++;
        end
        if (res_q.size() > 0 && r) void'(res_q.pop_front());
        if (g_cnt == COUNT) begin
            res_q.push_back(fold(g_sum, ACC));
            g_sum = 0; g_cnt = 0;
        end
        if (res_q.size() > 0) m_sum = res_q[0];
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        res_q.delete(); g_sum = 0; g_cnt = 0; m_sum = 0; m_ovr = 1'b0;
        #1;
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".out_sum"},   64'(out_sum),   64'd0);
        check({tag, ".in_ready"},  64'(in_ready),  64'd1);
        check({tag, ".overrun"},   64'(overrun),   64'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] rp;

        // Reset state
        do_reset("rst0");

        // Basic group 10,20,30,40 with consumer always ready
        step("bas0", 1'b1, 16'd10, 1'b0, 1'b1);
        step("bas1", 1'b1, 16'd20, 1'b0, 1'b1);
        step("bas2", 1'b1, 16'd30, 1'b0, 1'b1);
        check("bas_no_early", 64'(out_valid), 64'd0);
        step("bas3", 1'b1, 16'd40, 1'b0, 1'b1);
        check("bas_valid", 64'(out_valid), 64'd1);
        check("bas_sum",   64'(out_sum),   64'd100);
        step("bas4", 1'b0, 16'd0, 1'b0, 1'b1);
        check("bas_one_cycle", 64'(out_valid), 64'd0);

        // Backpressure: two groups with consumer stalled fill slot and pend
        for (int i = 0; i < 4; i++) step("bp1", 1'b1, 16'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("bp2", 1'b1, 16'd2, 1'b0, 1'b0);
        check("bp_held_sum", 64'(out_sum),  64'd4);
        check("bp_stall",    64'(in_ready), 64'd0);

        // Overrun while stalled
        step("ovr0", 1'b1, 16'd5, 1'b0, 1'b0);
        check("ovr_set", 64'(overrun), 64'd1);

        // Release for one cycle: pending result moves up, stall ends
        step("bp_rel", 1'b0, 16'd0, 1'b0, 1'b1);
        check("bp_pend_sum", 64'(out_sum),  64'd8);
        check("bp_ready",    64'(in_ready), 64'd1);
        step("bp_drain", 1'b0, 16'd0, 1'b0, 1'b1);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Clear mid-group discards 7,7 and the 9 offered alongside it
        step("clr0", 1'b1, 16'd7, 1'b0, 1'b1);
        step("clr1", 1'b1, 16'd7, 1'b0, 1'b1);
        step("clr2", 1'b1, 16'd9, 1'b1, 1'b1);
        step("clr3", 1'b1, 16'd1, 1'b0, 1'b1);
        step("clr4", 1'b1, 16'd2, 1'b0, 1'b1);
        step("clr5", 1'b1, 16'd3, 1'b0, 1'b1);
        check("clr_no_result", 64'(out_valid), 64'd0);
        step("clr6", 1'b1, 16'd4, 1'b0, 1'b1);
        check("clr_sum", 64'(out_sum), 64'd10);
        step("clr7", 1'b0, 16'd0, 1'b0, 1'b1);
        check("ovr_still", 64'(overrun), 64'd1);

        // Width boundary on both the 18-bit and 17-bit instances
        do_reset("rst_w");
        for (int i = 0; i < 4; i++) step("wid", 1'b1, 16'd65025, 1'b0, 1'b1);
        check("wid_sum18", 64'(out_sum), 64'd260100);
        check("wid_valid17", 64'(out_valid2), 64'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
        check("wid_sum17", 64'(out_sum2), 64'd131071);
`else
        check("wid_sum17", 64'(out_sum2), 64'd129028);
`endif
        check("wid_ready17", 64'(in_ready2), 64'd1);
        check("wid_ovr17",   64'(overrun2),  64'd0);
        step("wid_drain", 1'b0, 16'd0, 1'b0, 1'b1);

        // Reset mid-operation: held result plus a partial group
        for (int i = 0; i < 4; i++) step("mid_g", 1'b1, 16'd5, 1'b0, 1'b0);
        step("mid_p0", 1'b1, 16'd6, 1'b0, 1'b0);
        step("mid_p1", 1'b1, 16'd6, 1'b0, 1'b0);
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) step("mid_new", 1'b1, 16'd3, 1'b0, 1'b1);
        check("mid_new_sum", 64'(out_sum), 64'd12);

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            rp = 16'($urandom);
            step("rnd", $urandom_range(0, 3) != 0, rp,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
